// File: rtl/instr_issue.sv
// instr_issue: instruction FIFO, IR load/issue FSM and field decode for the datapath controller
module instr_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             waiting,
  input  logic [1:0]       reg_sel,
  output logic             start,
  output logic [2:0]       opcode,
  output logic [1:0]       ALU_op,
  output logic [1:0]       shift_op,
  output logic [2:0]       r_addr,
  output logic [15:0]      sximm8,
  output logic [15:0]      sximm5,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [15:0]      mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      ir_q, ir_d;
  logic             seen_low_q, seen_low_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             push, pop;
  // full/empty come from the occupancy count, so a pop never frees a slot for the same cycle's push
  assign in_ready = count_q != CW'(DEPTH);
  assign empty    = count_q == '0;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && waiting && !empty;
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    ir_d       = pop ? mem[rd_ptr_q] : ir_q;
    state_d    = state_q;
    seen_low_d = seen_low_q;
    retired_d  = retired_q;
    case (state_q)
      IDLE:  state_d = pop ? ISSUE : IDLE;
      ISSUE: begin
        state_d    = BUSY;
        seen_low_d = 1'b0;
      end
      BUSY: begin
        seen_low_d = seen_low_q || !waiting;
        state_d    = (seen_low_q && waiting) ? IDLE : BUSY;
        retired_d  = (seen_low_q && waiting) ? retired_q + 1'b1 : retired_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      seen_low_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      seen_low_q <= seen_low_d;
      retired_q  <= retired_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_instr;
  end
  assign start    = state_q == ISSUE;
  assign busy     = state_q != IDLE;
  assign retired  = retired_q;
  assign opcode   = ir_q[15:13];
  assign ALU_op   = ir_q[12:11];
  assign shift_op = ir_q[4:3];
  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
  assign r_addr   = reg_sel == 2'b00 ? ir_q[2:0] :
                    reg_sel == 2'b01 ? ir_q[7:5] :
                    reg_sel == 2'b10 ? ir_q[10:8] : 3'b000;
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: table-driven and scoreboard bench for instr_issue
module tb_instr_issue;
  logic        clk = 0, rst_n = 0, in_valid = 0, waiting = 0;
  logic [15:0] in_instr = 0;
  logic [1:0]  reg_sel = 2'b11;
  logic        in_ready, start, busy, empty;
  logic [2:0]  opcode, r_addr;
  logic [1:0]  ALU_op, shift_op;
  logic [15:0] sximm8, sximm5;
  logic [7:0]  retired;
  instr_issue #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .waiting(waiting), .reg_sel(reg_sel), .start(start), .opcode(opcode), .ALU_op(ALU_op),
    .shift_op(shift_op), .r_addr(r_addr), .sximm8(sximm8), .sximm5(sximm5), .busy(busy),
    .retired(retired), .empty(empty)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, starts = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  wire  [38:0] dut_fields = {opcode, ALU_op, shift_op, sximm8, sximm5};
  typedef struct {
    logic [15:0] instr;
    logic [38:0] fields;
    logic [11:0] ra;
  } vec_t;
  vec_t tbl [6];
  logic [15:0] b2b [5];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [2:0] model_raddr(input logic [15:0] i, input logic [1:0] s);
    case (s)
      2'b00:   return i[2:0];
      2'b01:   return i[7:5];
      2'b10:   return i[10:8];
      default: return 3'd0;
    endcase
  endfunction
  function automatic logic [38:0] model_fields(input logic [15:0] i);
    return {i[15:13], i[12:11], i[4:3], {{8{i[7]}}, i[7:0]}, {{11{i[4]}}, i[4:0]}};
  endfunction
  // scoreboard: every start must match the oldest accepted instruction
  always @(negedge clk) begin
    if (rst_n && start) begin
      starts++;
      if (exp_q.size() == 0) check("unexpected_start", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("issue_fields", dut_fields, model_fields(mon_e));
        check("issue_raddr", r_addr, model_raddr(mon_e, reg_sel));
      end
    end
  end
  task automatic push(input logic [15:0] instr);
    bit done = 0;
    in_valid = 1;
    in_instr = instr;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (done) exp_q.push_back(instr);
    else check("push_timeout", 0, 1);
  endtask
  task automatic wait_start(output bit ok);
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      ok = start;
    end
    if (!ok) check("start_timeout", 0, 1);
  endtask
  task automatic finish_exec(input int lows);
    bit idle = 0;
    @(posedge clk);
    #1 waiting = 0;
    repeat (lows) @(posedge clk);
    #1 waiting = 1;
    for (int n = 0; n < 30 && !idle; n++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) check("busy_timeout", 0, 1);
  endtask
  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    waiting = 0;
    @(posedge clk);
    #1 rst_n = 1;
    exp_q.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int s0;
    logic [15:0] r;
    tbl[0] = '{16'hD105, {3'b110, 2'b10, 2'b00, 16'h0005, 16'h0005}, {3'd0, 3'd1, 3'd0, 3'd5}};
    tbl[1] = '{16'hA140, {3'b101, 2'b00, 2'b00, 16'h0040, 16'h0000}, {3'd0, 3'd1, 3'd2, 3'd0}};
    tbl[2] = '{16'h00F0, {3'b000, 2'b00, 2'b10, 16'hFFF0, 16'hFFF0}, {3'd0, 3'd0, 3'd7, 3'd0}};
    tbl[3] = '{16'h001F, {3'b000, 2'b00, 2'b11, 16'h001F, 16'hFFFF}, {3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[4] = '{16'h7FFF, {3'b011, 2'b11, 2'b11, 16'hFFFF, 16'hFFFF}, {3'd0, 3'd7, 3'd7, 3'd7}};
    tbl[5] = '{16'h8A6C, {3'b100, 2'b01, 2'b01, 16'h006C, 16'h000C}, {3'd0, 3'd2, 3'd3, 3'd4}};
    b2b = '{16'h1111, 16'h2345, 16'hC0DE, 16'h4A5F, 16'hBEEF};
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_retired", retired, 0);
    check("rst_fields", dut_fields, 0);
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      #1 check("rst_raddr", r_addr, 0);
    end
    reg_sel = 2'b10;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 waiting = 1;
      push(tbl[i].instr);
      @(negedge clk);
      check("start_not_early", start, 0);
      @(negedge clk);
      check("start_at_k2", start, 1);
      if (!start) wait_start(ok);
      check("tbl_fields", dut_fields, tbl[i].fields);
      @(posedge clk);
      #1 waiting = 0;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        reg_sel = 2'(s);
        #1;
        check("tbl_raddr", r_addr, tbl[i].ra[3*s +: 3]);
        check("tbl_ir_stable", dut_fields, tbl[i].fields);
        check("tbl_busy", busy, 1);
      end
      reg_sel = 2'b10;
      @(posedge clk);
      #1 waiting = 1;
      ok = 0;
      for (int n = 0; n < 30 && !ok; n++) begin
        @(negedge clk);
        ok = !busy;
      end
      check("tbl_done", ok, 1);
      check("tbl_retired", retired, i + 1);
      check("tbl_one_start", starts, i + 1);
    end
    do_reset();
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) push(b2b[j]);
    @(negedge clk);
    check("full_ready_low", in_ready, 0);
    in_valid = 1;
    in_instr = b2b[4];
    repeat (3) begin
      @(negedge clk);
      check("fifth_held", in_ready, 0);
    end
    @(posedge clk);
    #1 in_valid = 0;
    waiting = 1;
    s0 = starts;
    for (int j = 0; j < 4; j++) begin
      wait_start(ok);
      finish_exec(3);
    end
    check("b2b_retired", retired, 4);
    repeat (10) @(negedge clk);
    check("b2b_starts", starts - s0, 4);
    check("b2b_empty", empty, 1);
    do_reset();
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) push(b2b[j]);
    waiting = 1;
    wait_start(ok);
    finish_exec(2);
    check("pre_rst_retired", retired, 1);
    wait_start(ok);
    @(posedge clk);
    #1 waiting = 0;
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    exp_q.delete();
    waiting = 1;
    @(negedge clk);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_retired", retired, 0);
    s0 = starts;
    repeat (10) @(negedge clk);
    check("mid_rst_no_start", starts, s0);
    do_reset();
    waiting = 1;
    for (int n = 0; n < 256; n++) begin
      @(posedge clk);
      #1 r = 16'($urandom);
      push(r);
      wait_start(ok);
      finish_exec(1);
      if (n == 254) check("retired_255", retired, 255);
    end
    check("retired_wrap", retired, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction buffer and issue stage directly upstream of the datapath controller. It accepts 16-bit instructions over a valid/ready handshake and holds them in a small FIFO. When the controller reports `waiting`, it loads the next instruction into the instruction register (IR) and pulses `start`. It decodes the IR into the controller's `opcode`/`ALU_op`/`shift_op` inputs, the register-file address selected by the controller's `reg_sel`, and the sign-extended immediates.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2)
- `CNT_W`, 8: width of retired-instruction counter

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  producer has an instruction
- `in_instr`  in  16  instruction word
- `in_ready`  out  1  FIFO can accept; = !full
- `waiting`  in  1  controller idle/ready for start
- `reg_sel`  in  2  controller register select
- `start`  out  1  one-cycle issue pulse to controller
- `opcode`  out  3  IR[15:13]
- `ALU_op`  out  2  IR[12:11]
- `shift_op`  out  2  IR[4:3]
- `r_addr`  out  3  register-file address, decoded per `reg_sel`
- `sximm8`  out  16  sign-extended IR[7:0]
- `sximm5`  out  16  sign-extended IR[4:0]
- `busy`  out  1  state != IDLE
- `retired`  out  CNT_W  count of completed instructions
- `empty`  out  1  FIFO empty

## Operation
- FIFO push when `in_valid && in_ready`. No bypass: a pop in the same cycle does not free a slot for that cycle's push.
- `r_addr` is combinational: `reg_sel` 00→Rm IR[2:0], 01→Rd IR[7:5], 10→Rn IR[10:8], 11→3'b000.
- Field outputs are combinational from the IR only, never from the FIFO head.
- FSM states:
  - IDLE: if `waiting && !empty`, pop the head into IR and go to ISSUE. Otherwise stay.
  - ISSUE: `start`=1 for this cycle only. Go to BUSY; clear `seen_low`.
  - BUSY: set `seen_low` when `waiting`=0. When `seen_low && waiting`, increment `retired` and go to IDLE.
- `retired` wraps modulo 2^CNT_W.
- The IR is held constant from the pop until the next pop, so the fields are stable for the whole controller execution.
- `waiting` falling in IDLE or ISSUE is ignored; there is no error state.
- Reset has priority over everything, including mid-execution. It clears the FIFO pointers and count, and sets IR=0, state=IDLE, `seen_low`=0, `retired`=0. Instructions in flight are discarded.
- Reset values of outputs:
  - `in_ready`=1, `start`=0, `busy`=0, `empty`=1, `retired`=0
  - `opcode`/`ALU_op`/`shift_op`=0, `sximm8`=`sximm5`=0
  - `r_addr`=0 for any `reg_sel`

## Timing
- Push at edge k into an empty FIFO with IDLE and `waiting`=1:
  - pop into IR at edge k+1
  - `start` high during cycle k+1..k+2
  - controller samples `start` at edge k+2
- Minimum issue-to-issue spacing is the controller's execution length plus 2 cycles (ISSUE cycle, plus the IDLE cycle before the pop).
- FIFO full after DEPTH pushes with no pop; `in_ready` drops the cycle after the DEPTH-th push.
- Pointers wrap modulo DEPTH; full/empty are distinguished by an occupancy count, 0..DEPTH.
- `busy`, `start` and `empty` are registered-state decodes and are glitch-free relative to `clk`.

## Test plan
- Reset, `reg_sel`=11: `in_ready`=1, `empty`=1, `start`=0, `busy`=0, `retired`=0, `r_addr`=0, all fields 0.
- Push 16'hD105 (MOV R1,#5) with `waiting` held 1; the bench model drops `waiting` for 3 cycles after `start`:
  - exactly one `start` pulse, 2 cycles after the push edge
  - `opcode`=110, `ALU_op`=10, `sximm8`=16'h0005
  - `reg_sel`=10 gives `r_addr`=1
  - `retired`=1 after `waiting` returns
- Push 16'hA140 (ADD R2,R1,R0):
  - `reg_sel` 10/01/00 gives `r_addr` 1/2/0
  - `opcode`=101, `ALU_op`=00
  - IR stays stable while `busy`
- Push 5 instructions back-to-back with `waiting`=0:
  - `in_ready` low after the 4th push; the 5th is held by the producer
  - after `waiting`=1, issue order matches push order
  - `retired`=4 after all 4 complete
- Assert `rst_n`=0 for one edge while BUSY with 2 entries queued: next cycle `empty`=1, `busy`=0, `retired`=0, and no `start` follows.
- 16'h00F0 / 16'h001F: `sximm8`=16'hFFF0, `sximm5`=16'hFFFF. 256 completions with CNT_W=8: `retired` wraps to 0.
